// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, flit type and the output arbiter
// state encoding. Imported by the router blocks that handle flits.
package noc_pkg;

    localparam int FLIT_W   = 39;
    localparam int TAIL_BIT = 38;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

endpackage

// File: rtl/noc_rr_packet_arbiter_rr_pick4.sv
// rr_pick4: combinational 4-way round-robin picker.
//   req[3:0]   request vector
//   ptr[1:0]   highest-priority index for this pick
//   gnt_valid  some request is set
//   gnt_id     first set request scanning ptr, ptr+1, ... modulo 4
// Shared with the input-VC allocator, so it carries no state of its own.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       gnt_valid,
    output logic [1:0] gnt_id
);

    // Walk from the lowest-priority offset up so the highest-priority hit
    // is the last assignment and wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                gnt_valid = 1'b1;
                gnt_id    = ptr + 2'(k);
            end
        end
    end

endmodule

// File: rtl/noc_rr_packet_arbiter.sv
// noc_rr_packet_arbiter: 4-requester round-robin arbiter with packet locking
// and one registered output stage (valid/ready).
//   clk, rst_n   clock, async active-low reset
//   in_valid     per-requester flit valid
//   in_data      flattened flits, requester i at [i*WIDTH +: WIDTH]
//   in_ready     per-requester accept (combinational)
//   out_valid    registered flit valid
//   out_data     registered flit
//   out_ready    downstream accept
//   out_src      requester that supplied out_data
//   busy         a packet currently holds the grant
module noc_rr_packet_arbiter #(
    parameter int WIDTH    = noc_pkg::FLIT_W,
    parameter int N_IN     = 4,
    parameter int TAIL_BIT = noc_pkg::TAIL_BIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN-1:0]       in_valid,
    input  logic [N_IN*WIDTH-1:0] in_data,
    output logic [N_IN-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  out_ready,
    output logic [1:0]            out_src,
    output logic                  busy
);

    import noc_pkg::*;

    arb_state_e       state;
    logic [1:0]       rr_ptr;
    logic [1:0]       lock_id;
    logic             load_en;
    logic             pick_valid;
    logic [1:0]       pick_id;
    logic [1:0]       gnt_id;
    logic             gnt_ok;
    logic             xfer;
    logic [WIDTH-1:0] gnt_flit;

    // The output stage can take a new flit when empty or draining this cycle.
    assign load_en = !out_valid || out_ready;

    rr_pick4 u_pick (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .gnt_valid (pick_valid),
        .gnt_id    (pick_id)
    );

    // While locked the owner keeps in_ready even with in_valid low, so a
    // stalled packet bubbles the output instead of yielding the port.
    assign gnt_id = (state == ARB_LOCKED) ? lock_id : pick_id;
    assign gnt_ok = (state == ARB_LOCKED) || pick_valid;

    always_comb begin
        in_ready         = '0;
        in_ready[gnt_id] = gnt_ok && load_en;
    end

    assign xfer     = in_valid[gnt_id] && in_ready[gnt_id];
    assign gnt_flit = in_data[int'(gnt_id)*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            rr_ptr    <= 2'd0;
            lock_id   <= 2'd0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= gnt_flit;
                out_src   <= gnt_id;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ARB_IDLE: begin
                    if (xfer) begin
                        // Pointer moves past the winner at packet start, so
                        // after this packet another requester goes first.
                        rr_ptr <= gnt_id + 2'd1;
                        if (!gnt_flit[TAIL_BIT]) begin
                            state   <= ARB_LOCKED;
                            lock_id <= gnt_id;
                            busy    <= 1'b1;
                        end
                    end
                end
                ARB_LOCKED: begin
                    if (xfer && gnt_flit[TAIL_BIT]) begin
                        state <= ARB_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_rr_packet_arbiter.sv
// Directed bench for noc_rr_packet_arbiter. Expected output flits are queued
// as stimulus is driven and compared by an output monitor on each handshake.
module tb_noc_rr_packet_arbiter;

    localparam int W = 39;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     in_valid;
    logic [4*W-1:0] in_data;
    logic [3:0]     in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready;
    logic [1:0]     out_src;
    logic           busy;

    typedef struct {
        logic [1:0]   src;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    noc_rr_packet_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_src   (out_src),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic tail, input logic [7:0] pl);
        logic [W-1:0] f;
        f      = '0;
        f[38]  = tail;
        f[7:0] = pl;
        return f;
    endfunction

    task automatic setd(input int i, input logic [W-1:0] f);
        in_data[i*W +: W] = f;
    endtask

    task automatic push(input int s, input logic [W-1:0] f);
        exp_t e;
        e.src  = s[1:0];
        e.data = f;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output scoreboard: every downstream handshake must match the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_underflow observed src=%0d data=%0h expected none", out_src, out_data);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("out_src", 64'(out_src), 64'(e.src));
                chk("out_data", 64'(out_data), 64'(e.data));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_out_data", 64'(out_data), 0);
        rst_n = 1'b1;

        // Idle: nothing requested for 5 cycles.
        for (int k = 0; k < 5; k++) begin
            step();
            chk("idle_out_valid", 64'(out_valid), 0);
            chk("idle_in_ready", 64'(in_ready), 0);
            chk("idle_busy", 64'(busy), 0);
        end

        // Fairness: all four single-flit requesters, order 0,1,2,3,0.
        for (int i = 0; i < 4; i++) setd(i, mk(1'b1, 8'((i + 1) * 16)));
        in_valid = 4'b1111;
        push(0, mk(1, 8'h10)); push(1, mk(1, 8'h20)); push(2, mk(1, 8'h30));
        push(3, mk(1, 8'h40)); push(0, mk(1, 8'h10));
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_out_valid", 64'(out_valid), 1);
        end
        in_valid = '0;
        step();
        chk("rr_drain_valid", 64'(out_valid), 0);
        chk("rr_sb_empty", 64'(sb.size()), 0);

        // Locked 3-flit packet on input 2 while 0 and 3 wait (rr_ptr=1).
        setd(0, mk(1, 8'h03)); setd(3, mk(1, 8'h33)); setd(2, mk(0, 8'h21));
        in_valid = 4'b1101;
        push(2, mk(0, 8'h21)); push(2, mk(0, 8'h22)); push(2, mk(1, 8'h23));
        push(3, mk(1, 8'h33)); push(0, mk(1, 8'h03));
        step();
        setd(2, mk(0, 8'h22));
        #1;
        chk("lock_busy", 64'(busy), 1);
        chk("lock_in_ready_a", 64'(in_ready), 64'h4);
        step();
        setd(2, mk(1, 8'h23));
        #1;
        chk("lock_in_ready_b", 64'(in_ready), 64'h4);
        step();
        in_valid = 4'b1001;
        #1;
        chk("unlock_busy", 64'(busy), 0);
        chk("next_winner_3", 64'(in_ready), 64'h8);
        step();
        step();
        in_valid = '0;
        step();
        chk("lock_sb_empty", 64'(sb.size()), 0);

        // Backpressure: out_ready low 4 cycles with a flit held (rr_ptr=1).
        setd(1, mk(1, 8'h51)); setd(2, mk(1, 8'h52)); setd(0, mk(1, 8'h50));
        in_valid = 4'b0010;
        push(1, mk(1, 8'h51)); push(2, mk(1, 8'h52)); push(0, mk(1, 8'h50));
        step();
        out_ready = 1'b0;
        in_valid  = 4'b0101;
        #1;
        chk("stall_in_ready0", 64'(in_ready), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("stall_in_ready", 64'(in_ready), 0);
            chk("stall_valid", 64'(out_valid), 1);
            chk("stall_data", 64'(out_data), 64'(mk(1, 8'h51)));
            chk("stall_src", 64'(out_src), 1);
        end
        out_ready = 1'b1;
        #1;
        chk("resume_winner_2", 64'(in_ready), 64'h4);
        step();
        in_valid = 4'b0001;
        #1;
        chk("resume_winner_0", 64'(in_ready), 64'h1);
        step();
        in_valid = '0;
        step();
        chk("stall_sb_empty", 64'(sb.size()), 0);

        // Locked owner 1 goes quiet for 3 cycles while input 0 waits (rr_ptr=1).
        setd(1, mk(0, 8'h61)); setd(0, mk(1, 8'h60));
        in_valid = 4'b0011;
        push(1, mk(0, 8'h61)); push(1, mk(1, 8'h62)); push(0, mk(1, 8'h60));
        step();
        in_valid = 4'b0001;
        #1;
        chk("gap_in_ready0", 64'(in_ready), 64'h2);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("gap_out_valid", 64'(out_valid), 0);
            chk("gap_busy", 64'(busy), 1);
            chk("gap_in_ready", 64'(in_ready), 64'h2);
        end
        setd(1, mk(1, 8'h62));
        in_valid = 4'b0011;
        step();
        #1;
        chk("gap_unlock_busy", 64'(busy), 0);
        chk("gap_next_0", 64'(in_ready), 64'h1);
        step();
        in_valid = '0;
        step();
        chk("gap_sb_empty", 64'(sb.size()), 0);

        // Reset while locked on input 3 (rr_ptr=1); in-flight flit is dropped.
        setd(3, mk(0, 8'h71));
        in_valid = 4'b1000;
        step();
        out_ready = 1'b0;
        in_valid  = '0;
        #1;
        chk("pre_rst_busy", 64'(busy), 1);
        chk("pre_rst_valid", 64'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 0);
        chk("arst_out_valid", 64'(out_valid), 0);
        chk("arst_out_data", 64'(out_data), 0);
        chk("arst_out_src", 64'(out_src), 0);
        chk("arst_in_ready", 64'(in_ready), 0);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        setd(0, mk(1, 8'h80)); setd(3, mk(1, 8'h83));
        in_valid = 4'b1001;
        push(0, mk(1, 8'h80)); push(3, mk(1, 8'h83));
        #1;
        chk("post_rst_winner_0", 64'(in_ready), 64'h1);
        step();
        step();
        in_valid = '0;
        step();
        chk("post_rst_valid", 64'(out_valid), 0);
        chk("final_sb_empty", 64'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
